// File: rtl/mem_responder_if.sv
//==============================================================================
// Module      : mem_responder_if
// Description : Request/response handshake between the control FSM
//               (master) and the memory responder (slave).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface mem_responder_if;
    logic        memread;
    logic        memwrite;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        ready;

    modport master (
        output memread, memwrite, addr, wdata,
        input  rdata, ready
    );

    modport slave (
        input  memread, memwrite, addr, wdata,
        output rdata, ready
    );
endinterface

`default_nettype wire

// File: rtl/mem_responder.sv
//==============================================================================
// Module      : mem_responder
// Description : Serves memread/memwrite strobes from a synchronous block RAM
//               or a small memory-mapped I/O page (LED, SW, CYCLE, STATUS).
//               Every transaction ends with a one-cycle ready pulse.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_responder #(
    parameter int          RAM_WAIT = 1,          // RAM read latency, 1..3
    parameter logic [15:0] IO_BASE  = 16'hFF00    // first address of the I/O page
) (
    input  wire logic        clk,
    input  wire logic        reset,               // asynchronous, active-low
    mem_responder_if.slave   bus,
    output logic [15:0]      ram_addr,
    output logic [15:0]      ram_wdata,
    output logic             ram_we,
    input  wire logic [15:0] ram_rdata,
    input  wire logic [15:0] sw,
    output logic [15:0]      led
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        IO   = 3'd3,
        DONE = 3'd4
    } state_t;

    // Wait counter runs 0..RAM_WAIT-1; the RD cycle holding this value is the last.
    localparam logic [1:0] WAIT_LAST = 2'(RAM_WAIT - 1);

    state_t      state;
    state_t      state_next;

    logic [15:0] addr_q;        // address frozen at accept
    logic [15:0] wdata_q;       // write data frozen at accept
    logic        is_wr_q;       // accepted transaction is a write
    logic [1:0]  wait_cnt;
    logic [15:0] rdata_q;
    logic [15:0] led_q;
    logic [15:0] cycle_q;
    logic [1:0]  status_q;      // bit0 strobe conflict, bit1 unmapped I/O access

    logic        accept;
    logic        req_is_io;
    logic [15:0] io_offset;

    assign accept    = (state == IDLE) && (bus.memread || bus.memwrite);
    assign req_is_io = (bus.addr >= IO_BASE);
    assign io_offset = addr_q - IO_BASE;

    assign bus.rdata = rdata_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign led       = led_q;

    // State register; reset abandons any in-flight transaction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and Moore outputs (ready in DONE, ram_we in WR).
    always_comb begin
        state_next = state;
        bus.ready  = 1'b0;
        ram_we     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.memwrite) begin
                    state_next = req_is_io ? IO : WR;
                end else if (bus.memread) begin
                    state_next = req_is_io ? IO : RD;
                end
            end
            RD: begin
                if (wait_cnt == WAIT_LAST) begin
                    state_next = DONE;
                end
            end
            WR: begin
                ram_we     = 1'b1;
                state_next = DONE;
            end
            IO: begin
                state_next = DONE;
            end
            DONE: begin
                bus.ready  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request latch, RAM read capture, I/O register access and STATUS flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q   <= 16'h0000;
            wdata_q  <= 16'h0000;
            is_wr_q  <= 1'b0;
            wait_cnt <= 2'd0;
            rdata_q  <= 16'h0000;
            led_q    <= 16'h0000;
            status_q <= 2'b00;
        end else begin
            if (accept) begin
                // A simultaneous read strobe loses to the write; flag it.
                addr_q   <= bus.addr;
                is_wr_q  <= bus.memwrite;
                wait_cnt <= 2'd0;
                if (bus.memwrite) begin
                    wdata_q <= bus.wdata;
                end
                if (bus.memwrite && bus.memread) begin
                    status_q[0] <= 1'b1;
                end
            end

            if (state == RD) begin
                wait_cnt <= wait_cnt + 2'd1;
                if (wait_cnt == WAIT_LAST) begin
                    rdata_q <= ram_rdata;
                end
            end

            if (state == IO) begin
                case (io_offset)
                    16'd0: begin
                        if (is_wr_q) begin
                            led_q <= wdata_q;
                        end else begin
                            rdata_q <= led_q;
                        end
                    end
                    16'd1: begin
                        if (!is_wr_q) begin
                            rdata_q <= sw;
                        end
                    end
                    16'd2: begin
                        // The write-clear lives in the counter block.
                        if (!is_wr_q) begin
                            rdata_q <= cycle_q;
                        end
                    end
                    16'd3: begin
                        if (is_wr_q) begin
                            status_q <= 2'b00;
                        end else begin
                            rdata_q <= {14'd0, status_q};
                        end
                    end
                    default: begin
                        status_q[1] <= 1'b1;
                        if (!is_wr_q) begin
                            rdata_q <= 16'h0000;
                        end
                    end
                endcase
            end
        end
    end

    // Free-running cycle counter; a write to CYCLE overrides that cycle's increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_q <= 16'h0000;
        end else if ((state == IO) && is_wr_q && (io_offset == 16'd2)) begin
            cycle_q <= 16'h0000;
        end else begin
            cycle_q <= cycle_q + 16'd1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
//==============================================================================
// Module      : tb_mem_responder
// Description : Scoreboard bench for mem_responder; one instance with
//               RAM_WAIT=1 (combinational RAM model) and one with RAM_WAIT=3
//               (RAM model with matching read pipeline).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mem_responder;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mem_responder_if b1 ();
    mem_responder_if b3 ();

    logic [15:0] ram_addr1, ram_wdata1, ram_rdata1, led1, sw1;
    logic [15:0] ram_addr3, ram_wdata3, ram_rdata3, led3, sw3;
    logic        ram_we1, ram_we3;

    mem_responder #(.RAM_WAIT(1), .IO_BASE(16'hFF00)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .bus       (b1.slave),
        .ram_addr  (ram_addr1),
        .ram_wdata (ram_wdata1),
        .ram_we    (ram_we1),
        .ram_rdata (ram_rdata1),
        .sw        (sw1),
        .led       (led1)
    );

    mem_responder #(.RAM_WAIT(3), .IO_BASE(16'hFF00)) dut3 (
        .clk       (clk),
        .reset     (reset),
        .bus       (b3.slave),
        .ram_addr  (ram_addr3),
        .ram_wdata (ram_wdata3),
        .ram_we    (ram_we3),
        .ram_rdata (ram_rdata3),
        .sw        (sw3),
        .led       (led3)
    );

    // RAM models: 256 words, synchronous write.
    logic [15:0] mem1 [256];
    logic [15:0] mem3 [256];
    logic [15:0] pipe3_a, pipe3_b;

    always @(posedge clk) if (ram_we1) mem1[ram_addr1[7:0]] <= ram_wdata1;
    always @(posedge clk) if (ram_we3) mem3[ram_addr3[7:0]] <= ram_wdata3;
    // Data appears exactly 3 edges after the address: valid only when sampled on time.
    always @(posedge clk) begin
        pipe3_a <= mem3[ram_addr3[7:0]];
        pipe3_b <= pipe3_a;
    end
    assign ram_rdata1 = mem1[ram_addr1[7:0]];
    assign ram_rdata3 = pipe3_b;

    typedef struct packed {
        logic        is_rd;
        logic [15:0] data;
    } sb_t;

    sb_t q1[$];
    sb_t q3[$];

    int          checks = 0;
    int          errors = 0;
    int          we1_cnt = 0;
    logic [15:0] we1_addr = '0, we1_data = '0;
    int          we3_cnt = 0;
    int          rdy3_cnt = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever a DUT presents ready.
    task automatic monitor();
        sb_t e;
        forever begin
            @(negedge clk);
            if (ram_we1) begin
                we1_cnt++;
                we1_addr = ram_addr1;
                we1_data = ram_wdata1;
            end
            if (ram_we3) we3_cnt++;
            if (b1.ready) begin
                if (q1.size() == 0) begin
                    chk("dut1_unexpected_ready", 16'd1, 16'd0);
                end else begin
                    e = q1.pop_front();
                    if (e.is_rd) chk("dut1_rdata", b1.rdata, e.data);
                end
            end
            if (b3.ready) begin
                rdy3_cnt++;
                if (q3.size() == 0) begin
                    chk("dut3_unexpected_ready", 16'd1, 16'd0);
                end else begin
                    e = q3.pop_front();
                    if (e.is_rd) chk("dut3_rdata", b3.rdata, e.data);
                end
            end
        end
    endtask

    // One transaction: present strobes, scramble addr/wdata after accept,
    // wait for ready (bounded), check latency, drop strobes after DONE.
    task automatic txn(input int sel, input logic wr, input logic rd,
                       input logic [15:0] a, input logic [15:0] d,
                       input int exp_lat, input logic [15:0] exp_rd);
        sb_t  e;
        int   n;
        logic seen;
        e.is_rd = rd & ~wr;
        e.data  = exp_rd;
        @(negedge clk);
        if (sel == 1) begin
            b1.memwrite = wr; b1.memread = rd; b1.addr = a; b1.wdata = d;
            q1.push_back(e);
        end else begin
            b3.memwrite = wr; b3.memread = rd; b3.addr = a; b3.wdata = d;
            q3.push_back(e);
        end
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                if (sel == 1) begin b1.addr = ~a; b1.wdata = ~d; end
                else          begin b3.addr = ~a; b3.wdata = ~d; end
            end
            seen = (sel == 1) ? b1.ready : b3.ready;
        end
        checks++;
        if (!seen || n != exp_lat) begin
            errors++;
            $display("FAIL latency addr=%h: got %0d cycles (seen=%0b) expected %0d", a, n, seen, exp_lat);
        end
        if (seen) begin
            @(posedge clk);
            #1;
        end else begin
            if (sel == 1) q1.delete(); else q3.delete();
        end
        if (sel == 1) begin b1.memwrite = 1'b0; b1.memread = 1'b0; end
        else          begin b3.memwrite = 1'b0; b3.memread = 1'b0; end
    endtask

    initial begin
        int we_before;
        int rdy_before;
        reset = 1'b0;
        b1.memread = 1'b0; b1.memwrite = 1'b0; b1.addr = '0; b1.wdata = '0;
        b3.memread = 1'b0; b3.memwrite = 1'b0; b3.addr = '0; b3.wdata = '0;
        sw1 = 16'h1234;
        sw3 = 16'h0000;
        fork
            monitor();
        join_none

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_ready",    {15'd0, b1.ready}, 16'd0);
        chk("rst_ram_we",   {15'd0, ram_we1},  16'd0);
        chk("rst_rdata",    b1.rdata,          16'd0);
        chk("rst_ram_addr", ram_addr1,         16'd0);
        chk("rst_led",      led1,              16'd0);
        @(posedge clk); #2;
        reset = 1'b1;

        // RAM write with address change after accept; one ram_we cycle.
        we_before = we1_cnt;
        txn(1, 1'b1, 1'b0, 16'h0010, 16'hBEEF, 2, 16'h0);
        chk("wr_we_count", 16'(we1_cnt - we_before), 16'd1);
        chk("wr_we_addr",  we1_addr, 16'h0010);
        chk("wr_we_data",  we1_data, 16'hBEEF);
        txn(1, 1'b0, 1'b1, 16'h0010, 16'h0000, 2, 16'hBEEF);

        // I/O page.
        txn(1, 1'b1, 1'b0, 16'hFF00, 16'h00A5, 2, 16'h0);
        chk("led_write", led1, 16'h00A5);
        txn(1, 1'b0, 1'b1, 16'hFF01, 16'h0000, 2, 16'h1234);
        we_before = we1_cnt;
        txn(1, 1'b1, 1'b0, 16'hFF01, 16'hFFFF, 2, 16'h0);
        chk("sw_write_led",   led1, 16'h00A5);
        chk("sw_write_no_we", 16'(we1_cnt - we_before), 16'd0);
        txn(1, 1'b0, 1'b1, 16'hFF00, 16'h0000, 2, 16'h00A5);
        txn(1, 1'b0, 1'b1, 16'hFF07, 16'h0000, 2, 16'h0000);
        txn(1, 1'b0, 1'b1, 16'hFF03, 16'h0000, 2, 16'h0002);
        txn(1, 1'b1, 1'b0, 16'hFF03, 16'h1234, 2, 16'h0);
        txn(1, 1'b0, 1'b1, 16'hFF03, 16'h0000, 2, 16'h0000);

        // Strobe conflict: write wins, STATUS[0] set, then cleared by write.
        we_before = we1_cnt;
        txn(1, 1'b1, 1'b1, 16'h0005, 16'h1111, 2, 16'h0);
        chk("conflict_we_count", 16'(we1_cnt - we_before), 16'd1);
        chk("conflict_we_addr",  we1_addr, 16'h0005);
        txn(1, 1'b0, 1'b1, 16'hFF03, 16'h0000, 2, 16'h0001);
        txn(1, 1'b0, 1'b1, 16'h0005, 16'h0000, 2, 16'h1111);
        txn(1, 1'b1, 1'b0, 16'hFF03, 16'h0000, 2, 16'h0);
        txn(1, 1'b0, 1'b1, 16'hFF03, 16'h0000, 2, 16'h0000);

        // CYCLE: clear, read right away (2 edges after clear), read again 10+3 later.
        txn(1, 1'b1, 1'b0, 16'hFF02, 16'h0000, 2, 16'h0);
        txn(1, 1'b0, 1'b1, 16'hFF02, 16'h0000, 2, 16'd2);
        repeat (10) @(posedge clk);
        txn(1, 1'b0, 1'b1, 16'hFF02, 16'h0000, 2, 16'd15);
        // Wrap: clear, let it reach FFFF, next read lands past the wrap.
        txn(1, 1'b1, 1'b0, 16'hFF02, 16'h0000, 2, 16'h0);
        repeat (65533) @(posedge clk);
        txn(1, 1'b0, 1'b1, 16'hFF02, 16'h0000, 2, 16'hFFFF);
        txn(1, 1'b0, 1'b1, 16'hFF02, 16'h0000, 2, 16'h0002);

        // RAM_WAIT=3 read; the preceding write leaves stale data in the pipeline.
        txn(3, 1'b1, 1'b0, 16'h0010, 16'hBEEF, 2, 16'h0);
        txn(3, 1'b1, 1'b0, 16'h0020, 16'h1111, 2, 16'h0);
        txn(3, 1'b0, 1'b1, 16'h0010, 16'h0000, 4, 16'hBEEF);
        repeat (5) @(negedge clk);
        chk("rdata_hold", b3.rdata, 16'hBEEF);

        // Reset mid-transaction on the RAM_WAIT=3 instance.
        txn(3, 1'b1, 1'b0, 16'hFF00, 16'h5A5A, 2, 16'h0);
        txn(3, 1'b0, 1'b1, 16'hFF07, 16'h0000, 2, 16'h0000);
        we_before  = we3_cnt;
        rdy_before = rdy3_cnt;
        @(negedge clk);
        b3.memread = 1'b1; b3.addr = 16'h0010;
        @(posedge clk);
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        b3.memread = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_ready_count", 16'(rdy3_cnt - rdy_before), 16'd0);
        chk("abort_we_count",    16'(we3_cnt - we_before),   16'd0);
        chk("abort_rdata",       b3.rdata,  16'd0);
        chk("abort_ram_addr",    ram_addr3, 16'd0);
        chk("abort_ram_wdata",   ram_wdata3, 16'd0);
        chk("abort_led3",        led3, 16'd0);
        chk("abort_led1",        led1, 16'd0);
        @(posedge clk); #2;
        reset = 1'b1;
        txn(3, 1'b0, 1'b1, 16'hFF03, 16'h0000, 2, 16'h0000);
        txn(3, 1'b0, 1'b1, 16'h0010, 16'h0000, 4, 16'hBEEF);

        repeat (3) @(negedge clk);
        chk("queue1_empty", 16'(q1.size()), 16'd0);
        chk("queue3_empty", 16'(q3.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the processor's multi-cycle control unit. It accepts the `memread`/`memwrite` strobes the control FSM raises during FETCH, LOAD and STOR, and serves each one from a synchronous block RAM or from a small memory-mapped I/O page. Each transaction completes with a one-cycle `ready` pulse. It replaces the fixed-latency assumption with a handshake the control FSM can stall on.

## Interface
- `RAM_WAIT`, default 1: RAM read latency in cycles; legal range 1..3.
- `IO_BASE`, default 16'hFF00: first address of the I/O page. Addresses >= `IO_BASE` go to I/O; all others go to RAM.

Ports:
- `clk` in 1: system clock, rising edge.
- `reset` in 1: one clock; reset is asynchronous and active-low.
- `memread` in 1: read request, held by the initiator until `ready`.
- `memwrite` in 1: write request, held by the initiator until `ready`.
- `addr` in 16: word address.
- `wdata` in 16: write data.
- `rdata` out 16: read data, registered; valid while `ready`=1, held until the next read completes.
- `ready` out 1: one-cycle completion pulse.
- `ram_addr` out 16: RAM address, registered.
- `ram_wdata` out 16: RAM write data, registered.
- `ram_we` out 1: RAM write enable.
- `ram_rdata` in 16: RAM read data, sampled `RAM_WAIT` cycles after `ram_addr` is valid.
- `sw` in 16: switch inputs.
- `led` out 16: LED register.

## Operation
- FSM states: IDLE, RD, WR, IO, DONE.
- IDLE:
  - If `memwrite`=1: latch `addr`/`wdata`. Go to IO if the address is in the I/O page, else WR.
  - Else if `memread`=1: latch `addr`. Go to IO or RD.
  - Else stay in IDLE.
- `memread` and `memwrite` both high in IDLE: the write wins and `STATUS[0]` is set (sticky).
- Latched `addr`/`wdata` are frozen for the whole transaction; input changes after acceptance are ignored.
- RD:
  - `ram_addr` = latched address.
  - A wait counter runs for `RAM_WAIT` cycles.
  - On the edge ending the last RD cycle, `rdata` <= `ram_rdata`, then go to DONE.
- WR: `ram_we`=1 for exactly this one cycle, with `ram_addr`/`ram_wdata` = latched values; then go to DONE.
- IO: one cycle. Register read/write happens at the edge ending the cycle; then go to DONE.
- DONE: `ready`=1 (Moore output); always go to IDLE.
- I/O page, offset = `addr` − `IO_BASE`:
  - 0, LED: read/write; read returns `led`.
  - 1, SW: read-only; read returns `sw`; writes are ignored.
  - 2, CYCLE: free-running 16-bit counter. Read returns its value. Any write clears it; the cleared value takes precedence over that cycle's increment.
  - 3, STATUS: bit0 = strobe conflict, bit1 = unmapped I/O access, bits 15:2 read 0. Any write clears both bits.
  - Any other offset: read returns 0, write is ignored, `STATUS[1]` set (sticky).
- CYCLE increments every clock after reset release and wraps FFFF→0000.
- `ram_we` is never asserted for I/O-page addresses.

## Timing
- Reset (async, `reset`=0):
  - Next state IDLE.
  - `ready`=0, `ram_we`=0.
  - `rdata`, `ram_addr`, `ram_wdata`, `led`, CYCLE and STATUS all = 0.
  - An in-flight transaction is abandoned: no `ram_we`, no `ready`.
- Latency, counted from the accept edge (the IDLE edge at which the strobe is seen):
  - RAM read: `ready` is high in cycle `RAM_WAIT`+1.
  - RAM write: `ready` is high in cycle 2.
  - I/O read or write: `ready` is high in cycle 2.
- The initiator deasserts strobes at the edge ending DONE. Because DONE always returns to IDLE, strobes are next sampled one edge later, so a single request can never be accepted twice.
- Back-to-back requests: minimum request-to-request spacing is latency + 1 cycle (the IDLE sample cycle).
- `led` and STATUS update at the edge ending IO.

## Test plan
- RAM write: `RAM_WAIT`=1, `memwrite`, `addr`=0010, `wdata`=BEEF → `ram_we` high exactly 1 cycle with `ram_addr`=0010 and `ram_wdata`=BEEF; `ready` pulses in cycle 2; `addr` changed to 0020 after accept has no effect.
- RAM read, `RAM_WAIT`=3: `memread`, `addr`=0010, RAM model returns BEEF → `ready` in cycle 4 with `rdata`=BEEF; `rdata` still BEEF 5 cycles later.
- I/O:
  - Write FF00←00A5 → `led`=00A5.
  - Read FF01 with `sw`=1234 → `rdata`=1234.
  - Write FF01 → `led` unchanged, no `ram_we`.
  - Read FF07 → `rdata`=0 and STATUS=0002.
- Counter and status:
  - Read FF02 → increases between two reads taken N cycles apart.
  - Write FF02 → next read is small (under 10).
  - Preload FFFF → wraps to 0000.
  - Both strobes high with `addr`=0005 → RAM write performed and STATUS=0001; write FF03 → STATUS=0000.
- Reset mid-transaction: `RAM_WAIT`=3 read, assert `reset`=0 during RD → `ready` never pulses; all outputs 0; the next read after release completes normally.
